// File: rtl/ecpri_tx.sv
// ---------------------------------------------------------------------------
// ecpri_tx -- eCPRI transmit-side Remote Memory Access response builder.
//
// A send_write_resp / send_read_resp pulse from ecpri_rx starts one frame.
// The block then writes a complete Ethernet + eCPRI RMA response (message
// type 0x04) into the tx packet RAM, one byte per clock. Read responses pull
// their data bytes from the cpri payload RAM. At the end, tx_done pulses and
// tx_len holds the frame length.
//
// Optional build macro: ECPRI_TX_VLAN_EN
//   When defined, a VLAN tag 0x81,0x00,VLAN_TCI is inserted at offsets 12-15
//   and the header grows from 30 to 34 bytes.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   send_write_resp/read_resp   one-cycle request pulses (read wins on a tie)
//   resp_payload_len            requested length N
//   rma_id, element_id,
//   rma_addr                    fields echoed back to the requester
//   dst_mac, src_mac            Ethernet addresses
//   addr_pl/data_pl/oe_pl/we_pl payload RAM port 1 (read only, 1-cycle latency)
//   addr_tx/data_tx/we_tx/oe_tx tx packet RAM port 0 (write only)
//   busy                        frame build in progress
//   tx_done, tx_len             completion pulse and frame length
//   req_dropped                 pulse when a request is ignored
// ---------------------------------------------------------------------------
module ecpri_tx #(
    parameter int              DATA_WIDTH   = 8,
    parameter int              ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] TX_BASE_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] PL_BASE_ADDR = '0,
    parameter int              MIN_FRAME    = 60,
    parameter logic [15:0]     VLAN_TCI     = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [7:0]            resp_payload_len,
    input  logic [7:0]            rma_id,
    input  logic [15:0]           element_id,
    input  logic [47:0]           rma_addr,
    input  logic [47:0]           dst_mac,
    input  logic [47:0]           src_mac,
    output logic [ADDR_WIDTH-1:0] addr_pl,
    input  logic [DATA_WIDTH-1:0] data_pl,
    output logic                  oe_pl,
    output logic                  we_pl,
    output logic [ADDR_WIDTH-1:0] addr_tx,
    inout  wire  [DATA_WIDTH-1:0] data_tx,
    output logic                  we_tx,
    output logic                  oe_tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           tx_len,
    output logic                  req_dropped
);

`ifdef ECPRI_TX_VLAN_EN
    localparam int VO = 4;
`else
    localparam int VO = 0;
`endif

    localparam logic [15:0] HDR_LEN = 16'(30 + VO);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

    typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] cyc;
    logic [15:0] cyc_nxt;
    logic [15:0] pos;
    logic [15:0] rel;
    logic        is_read_q;
    logic [7:0]  n_q;
    logic [7:0]  rma_id_q;
    logic [15:0] element_q;
    logic [47:0] rma_addr_q;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [15:0] tx_len_q;
    logic        drop_q;
    logic        req;
    logic        accept;
    logic        active;
    logic [15:0] data_len;
    logic [15:0] body_len;
    logic [15:0] frame_len;
    logic [15:0] payload_size;
    logic [7:0]  hdr_byte;
    logic [DATA_WIDTH-1:0] tx_byte;

    // Picks byte i (0 = most significant) out of a 48-bit field.
    function automatic logic [7:0] field_byte(input logic [47:0] v, input logic [2:0] i);
        logic [47:0] s;
        s = v >> {(3'd5 - i), 3'b000};
        return s[7:0];
    endfunction

    assign req    = send_write_resp | send_read_resp;
    assign accept = req && (state == IDLE);
    assign active = (state == HDR) || (state == DATA) || (state == PAD);

    // Length bookkeeping for the frame currently held in the capture registers.
    assign data_len     = is_read_q ? {8'd0, n_q} : 16'd0;
    assign body_len     = HDR_LEN + data_len;
    assign frame_len    = (body_len > MIN_LEN) ? body_len : MIN_LEN;
    assign payload_size = 16'd12 + data_len;

    // cyc counts clocks since the start edge; the byte written in cycle c sits
    // at frame offset c-1, so cycle 0 is a setup cycle with no write.
    assign pos = cyc - 16'd1;
    assign rel = pos - 16'(VO);

    // Next-state logic: the phase is decided by where the next cycle's byte
    // falls in the frame, which keeps header, data and pad back to back.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc + 16'd1;
        case (state)
            IDLE: begin
                if (req)
                    state_nxt = HDR;
            end
            HDR, DATA, PAD: begin
                if (cyc_nxt == frame_len + 16'd1)
                    state_nxt = DONE;
                else if (cyc_nxt <= HDR_LEN)
                    state_nxt = HDR;
                else if (cyc_nxt <= body_len)
                    state_nxt = DATA;
                else
                    state_nxt = PAD;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, cycle counter and request capture. A tie between the two request
    // pulses builds a read response but still reports the lost write request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cyc        <= 16'd0;
            is_read_q  <= 1'b0;
            n_q        <= 8'd0;
            rma_id_q   <= 8'd0;
            element_q  <= 16'd0;
            rma_addr_q <= 48'd0;
            dst_q      <= 48'd0;
            src_q      <= 48'd0;
            tx_len_q   <= 16'd0;
            drop_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= (req && (state != IDLE)) || (accept && send_write_resp && send_read_resp);
            if (accept) begin
                cyc        <= 16'd0;
                is_read_q  <= send_read_resp;
                n_q        <= resp_payload_len;
                rma_id_q   <= rma_id;
                element_q  <= element_id;
                rma_addr_q <= rma_addr;
                dst_q      <= dst_mac;
                src_q      <= src_mac;
            end else if (active) begin
                cyc <= cyc_nxt;
            end
            if (active && (state_nxt == DONE))
                tx_len_q <= frame_len;
        end
    end

    // Header and padding byte for the current offset; data bytes bypass this.
    always_comb begin
        hdr_byte = 8'h00;
        if (pos < 16'd6) begin
            hdr_byte = field_byte(dst_q, pos[2:0]);
        end else if (pos < 16'd12) begin
            hdr_byte = field_byte(src_q, 3'(pos - 16'd6));
        end else if (pos < 16'(12 + VO)) begin
            case (pos[1:0])
                2'd0: hdr_byte = 8'h81;
                2'd1: hdr_byte = 8'h00;
                2'd2: hdr_byte = VLAN_TCI[15:8];
                default: hdr_byte = VLAN_TCI[7:0];
            endcase
        end else begin
            case (rel)
                16'd12: hdr_byte = 8'hAE;
                16'd13: hdr_byte = 8'hFE;
                16'd14: hdr_byte = 8'h10;
                16'd15: hdr_byte = 8'h04;
                16'd16: hdr_byte = payload_size[15:8];
                16'd17: hdr_byte = payload_size[7:0];
                16'd18: hdr_byte = rma_id_q;
                16'd19: hdr_byte = is_read_q ? 8'h01 : 8'h11;
                16'd20: hdr_byte = element_q[15:8];
                16'd21: hdr_byte = element_q[7:0];
                16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27:
                    hdr_byte = field_byte(rma_addr_q, 3'(rel - 16'd22));
                // Offset 28 is the zero high byte of N and falls to the default.
                16'd29: hdr_byte = n_q;
                default: hdr_byte = 8'h00;
            endcase
        end
    end

    // Payload RAM addresses lead the tx write by one cycle to cover the
    // synchronous read latency; data_pl is then forwarded straight through.
    assign oe_pl   = active && (cyc >= HDR_LEN) && (cyc < body_len);
    assign addr_pl = oe_pl ? PL_BASE_ADDR + ADDR_WIDTH'(cyc - HDR_LEN) : '0;
    assign we_pl   = 1'b0;

    assign we_tx   = active && (cyc != 16'd0);
    assign addr_tx = we_tx ? TX_BASE_ADDR + ADDR_WIDTH'(pos) : '0;
    assign oe_tx   = 1'b0;
    assign tx_byte = (state == DATA) ? data_pl : DATA_WIDTH'(hdr_byte);
    assign data_tx = we_tx ? tx_byte : {DATA_WIDTH{1'bz}};

    assign busy        = active;
    assign tx_done     = (state == DONE);
    assign tx_len      = tx_len_q;
    assign req_dropped = drop_q;

endmodule

// File: tb/tb_ecpri_tx.sv
// ---------------------------------------------------------------------------
// tb_ecpri_tx -- scoreboard bench for ecpri_tx.
//
// Each request builds its expected frame as a byte list straight from the
// frame layout rules and queues the (address, byte) writes plus the frame
// length. A monitor pops and compares on every we_tx and tx_done. A payload
// RAM model with one-cycle read latency feeds data_pl.
// Honours ECPRI_TX_VLAN_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ecpri_tx;

    localparam logic [15:0] TX_BASE   = 16'hFFE0;
    localparam logic [15:0] PL_BASE   = 16'hFFF0;
    localparam int          MIN_FRAME = 60;
    localparam logic [15:0] TCI       = 16'h6005;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        send_write_resp;
    logic        send_read_resp;
    logic [7:0]  resp_payload_len;
    logic [7:0]  rma_id;
    logic [15:0] element_id;
    logic [47:0] rma_addr;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] addr_pl;
    logic [7:0]  data_pl;
    logic        oe_pl;
    logic        we_pl;
    logic [15:0] addr_tx;
    wire  [7:0]  data_tx;
    logic        we_tx;
    logic        oe_tx;
    logic        busy;
    logic        tx_done;
    logic [15:0] tx_len;
    logic        req_dropped;

    logic [7:0]  pl_mem [65536];
    wr_t         exp_q[$];
    int          len_q[$];
    int          checks;
    int          errors;
    int          drop_cnt;
    int          done_cnt;
    int          oe_cnt;

    ecpri_tx #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (16),
        .TX_BASE_ADDR(TX_BASE),
        .PL_BASE_ADDR(PL_BASE),
        .MIN_FRAME   (MIN_FRAME),
        .VLAN_TCI    (TCI)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .send_write_resp (send_write_resp),
        .send_read_resp  (send_read_resp),
        .resp_payload_len(resp_payload_len),
        .rma_id          (rma_id),
        .element_id      (element_id),
        .rma_addr        (rma_addr),
        .dst_mac         (dst_mac),
        .src_mac         (src_mac),
        .addr_pl         (addr_pl),
        .data_pl         (data_pl),
        .oe_pl           (oe_pl),
        .we_pl           (we_pl),
        .addr_tx         (addr_tx),
        .data_tx         (data_tx),
        .we_tx           (we_tx),
        .oe_tx           (oe_tx),
        .busy            (busy),
        .tx_done         (tx_done),
        .tx_len          (tx_len),
        .req_dropped     (req_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload RAM: synchronous read, one cycle of latency.
    initial data_pl = 8'h00;
    always @(posedge clk) begin
        if (oe_pl)
            data_pl <= pl_mem[addr_pl];
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Builds the expected frame from the layout rules and queues its writes.
    task automatic push_expected(input bit rd, input logic [7:0] n, input logic [7:0] id,
                                 input logic [15:0] el, input logic [47:0] ra,
                                 input logic [47:0] dm, input logic [47:0] sm,
                                 output int len);
        logic [7:0]  f[$];
        int          d;
        logic [15:0] p;
        d = rd ? int'(n) : 0;
        p = 16'(12 + d);
        for (int i = 0; i < 6; i++) f.push_back(dm[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(sm[47-8*i -: 8]);
`ifdef ECPRI_TX_VLAN_EN
        f.push_back(8'h81); f.push_back(8'h00);
        f.push_back(TCI[15:8]); f.push_back(TCI[7:0]);
`endif
        f.push_back(8'hAE); f.push_back(8'hFE);
        f.push_back(8'h10); f.push_back(8'h04);
        f.push_back(p[15:8]); f.push_back(p[7:0]);
        f.push_back(id);
        f.push_back(rd ? 8'h01 : 8'h11);
        f.push_back(el[15:8]); f.push_back(el[7:0]);
        for (int i = 0; i < 6; i++) f.push_back(ra[47-8*i -: 8]);
        f.push_back(8'h00); f.push_back(n);
        for (int k = 0; k < d; k++) f.push_back(pl_mem[16'(int'(PL_BASE) + k)]);
        while (f.size() < MIN_FRAME) f.push_back(8'h00);
        len = f.size();
        for (int i = 0; i < len; i++) exp_q.push_back('{addr: 16'(int'(TX_BASE) + i), data: f[i]});
        len_q.push_back(len);
    endtask

    // Drives one request pulse; on return the bench sits in cycle 0.
    task automatic apply_stimulus(input bit wr, input bit rd, input logic [7:0] n,
                                  input logic [7:0] id, input logic [15:0] el,
                                  input logic [47:0] ra, output int len);
        logic [47:0] dm;
        logic [47:0] sm;
        dm = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        sm = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        send_write_resp  = wr;
        send_read_resp   = rd;
        resp_payload_len = n;
        rma_id           = id;
        element_id       = el;
        rma_addr         = ra;
        dst_mac          = dm;
        src_mac          = sm;
        push_expected(rd, n, id, el, ra, dm, sm, len);
        @(negedge clk);
        send_write_resp = 1'b0;
        send_read_resp  = 1'b0;
        resp_payload_len = $urandom;
        rma_id           = $urandom;
    endtask

    // Waits for tx_done and checks it lands on cycle L+1; optionally injects
    // a write request while the frame is still being built.
    task automatic wait_done(input int exp_len, input int inject_at);
        int c;
        c = 0;
        check_output("busy_at_start", {63'd0, busy}, 64'd1);
        while (!tx_done && c < 400) begin
            @(negedge clk);
            c++;
            send_write_resp = (c == inject_at);
        end
        send_write_resp = 1'b0;
        check_output("done_cycle", 64'(c), 64'(exp_len + 1));
        check_output("bytes_left", 64'(exp_q.size()), 64'd0);
        check_output("busy_at_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"},    {63'd0, busy},        64'd0);
        check_output({tag, "_we_tx"},   {63'd0, we_tx},       64'd0);
        check_output({tag, "_oe_pl"},   {63'd0, oe_pl},       64'd0);
        check_output({tag, "_tx_done"}, {63'd0, tx_done},     64'd0);
        check_output({tag, "_dropped"}, {63'd0, req_dropped}, 64'd0);
        check_output({tag, "_tx_len"},  {48'd0, tx_len},      64'd0);
        check_output({tag, "_addr_tx"}, {48'd0, addr_tx},     64'd0);
        check_output({tag, "_addr_pl"}, {48'd0, addr_pl},     64'd0);
        check_output({tag, "_data_tx"}, {56'd0, data_tx},     {56'd0, 8'hzz});
        check_output({tag, "_we_pl_oe_tx"}, {62'd0, we_pl, oe_tx}, 64'd0);
    endtask

    // Monitor: compares every tx RAM write and every completion pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_dropped) drop_cnt++;
            if (oe_pl) oe_cnt++;
            if (we_tx) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr %0h data %0h, expected no write", addr_tx, data_tx);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_output("tx_addr", {48'd0, addr_tx}, {48'd0, e.addr});
                    check_output("tx_data", {56'd0, data_tx}, {56'd0, e.data});
                end
            end
            if (tx_done) begin
                done_cnt++;
                if (len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: tx_len %0d, expected no tx_done", tx_len);
                end else begin
                    check_output("tx_len", {48'd0, tx_len}, 64'(len_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int len;
        int oe0;
        int drop0;
        int done0;
        checks = 0; errors = 0; drop_cnt = 0; done_cnt = 0; oe_cnt = 0;
        reset = 1'b1;
        send_write_resp = 1'b0; send_read_resp = 1'b0;
        resp_payload_len = 8'd0; rma_id = 8'd0; element_id = 16'd0;
        rma_addr = 48'd0; dst_mac = 48'd0; src_mac = 48'd0;
        for (int i = 0; i < 65536; i++) pl_mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // Write response, N=4: header plus padding.
        oe0 = oe_cnt;
        apply_stimulus(1'b1, 1'b0, 8'd4, 8'h5A, 16'h0012, 48'h0000_0000_1000, len);
        wait_done(len, -1);
        check_output("t1_tx_len", {48'd0, tx_len}, 64'd60);
        check_output("t1_no_pl_read", 64'(oe_cnt - oe0), 64'd0);

        // Read response, N=40, payload k+0x80.
        for (int k = 0; k < 40; k++) pl_mem[16'(int'(PL_BASE) + k)] = 8'(k + 8'h80);
        oe0 = oe_cnt;
        apply_stimulus(1'b0, 1'b1, 8'd40, 8'h21, 16'hBEEF, 48'h1234_5678_9ABC, len);
        wait_done(len, -1);
`ifdef ECPRI_TX_VLAN_EN
        check_output("t2_tx_len", {48'd0, tx_len}, 64'd74);
`else
        check_output("t2_tx_len", {48'd0, tx_len}, 64'd70);
`endif
        check_output("t2_pl_reads", 64'(oe_cnt - oe0), 64'd40);

        // Both pulses together, then a write request mid-frame.
        drop0 = drop_cnt;
        apply_stimulus(1'b1, 1'b1, 8'd20, 8'h33, 16'h0102, 48'hA5A5_0000_5A5A, len);
        wait_done(len, 10);
        @(negedge clk);
        check_output("t3_drops", 64'(drop_cnt - drop0), 64'd2);

        // Reset asserted on cycle 20 of a read response.
        done0 = done_cnt;
        apply_stimulus(1'b0, 1'b1, 8'd100, 8'h44, 16'h0304, 48'h0000_0000_0044, len);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        len_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check_output("t4_no_done", 64'(done_cnt - done0), 64'd0);
        apply_stimulus(1'b1, 1'b0, 8'd7, 8'h55, 16'h0506, 48'h0000_0000_0055, len);
        wait_done(len, -1);
        check_output("t4_tx_len", {48'd0, tx_len}, 64'd60);

        // Read response with N=0.
        oe0 = oe_cnt;
        apply_stimulus(1'b0, 1'b1, 8'd0, 8'h66, 16'h0708, 48'h0000_0000_0066, len);
        wait_done(len, -1);
        check_output("t5_no_pl_read", 64'(oe_cnt - oe0), 64'd0);
        check_output("t5_tx_len", {48'd0, tx_len}, 64'd60);

        // Randomized requests, including long reads that wrap both RAMs.
        for (int t = 0; t < 8; t++) begin
            bit rd;
            logic [7:0] n;
            rd = 1'($urandom);
            n  = 8'($urandom);
            if (t == 0) begin rd = 1'b1; n = 8'd255; end
            oe0 = oe_cnt;
            apply_stimulus(~rd, rd, n, 8'($urandom), 16'($urandom),
                           {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, len);
            wait_done(len, -1);
            check_output("rand_pl_reads", 64'(oe_cnt - oe0), rd ? 64'(n) : 64'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_output("final_queue_empty", 64'(len_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
